// File: rtl/tx_xgmii_gearbox.sv
// rtl/tx_xgmii_gearbox.sv - 256-bit CGMII beat to 64-bit XGMII lane gearbox with idle/underrun handling
// Optional statistics counters: define TX_XGMII_GEARBOX_STATS_EN
module tx_xgmii_gearbox #(
  parameter int IN_WIDTH   = 256,
  parameter int OUT_WIDTH  = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk156,
  input  logic                   rst,
  input  logic                   in_vld,
  input  logic [IN_WIDTH-1:0]    txd,
  input  logic [IN_WIDTH/8-1:0]  txc,
  output logic                   in_rdy,
  output logic [OUT_WIDTH-1:0]   xgmii_txd,
  output logic [OUT_WIDTH/8-1:0] xgmii_txc,
  output logic                   ovf_err,
  output logic                   underrun_err
`ifdef TX_XGMII_GEARBOX_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [31:0]            GBX_TX_FRM_CNT,
  output logic [31:0]            GBX_UNDERRUN_CNT
`endif
);

  localparam int CW     = OUT_WIDTH / 8;
  localparam int IN_CW  = IN_WIDTH / 8;
  localparam int BW     = IN_WIDTH + IN_CW;
  localparam int LANES  = IN_WIDTH / OUT_WIDTH;
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW   = AW + 1;

  localparam logic [LW-1:0]        LAST_LANE = LW'(LANES - 1);
  localparam logic [CNTW-1:0]      FULL_CNT  = CNTW'(FIFO_DEPTH);
  localparam logic [OUT_WIDTH-1:0] IDLE_WORD = {CW{8'h07}};
  localparam logic [OUT_WIDTH-1:0] ERR_WORD  = {CW{8'hFE}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [BW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CNTW-1:0]      count;
  logic [LW-1:0]        lane_idx;

  logic                 empty, push, pop, lane_adv;
  logic [BW-1:0]        head;
  logic [IN_WIDTH-1:0]  head_txd;
  logic [IN_CW-1:0]     head_txc;
  logic [OUT_WIDTH-1:0] lane_d;
  logic [CW-1:0]        lane_c;
  logic                 is_start, has_term, frm_done, und_nxt;
  logic [OUT_WIDTH-1:0] txd_nxt;
  logic [CW-1:0]        txc_nxt;

  assign empty    = (count == '0);
  assign head     = mem[rd_ptr];
  assign head_txd = head[IN_WIDTH-1:0];
  assign head_txc = head[BW-1:IN_WIDTH];
  assign lane_d   = head_txd[int'(lane_idx)*OUT_WIDTH +: OUT_WIDTH];
  assign lane_c   = head_txc[int'(lane_idx)*CW +: CW];
  assign is_start = lane_c[0] && (lane_d[7:0] == 8'hFB);

  // Every non-empty cycle consumes one lane, so the head beat leaves on its last lane
  assign pop    = !empty && (lane_idx == LAST_LANE);
  assign in_rdy = (count < FULL_CNT) || pop;
  assign push   = in_vld && in_rdy;

  always_comb begin
    has_term = 1'b0;
    for (int b = 0; b < CW; b++) begin
      if (lane_c[b] && (lane_d[8*b +: 8] == 8'hFD)) has_term = 1'b1;
    end
  end

  always_ff @(posedge clk156 or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    txd_nxt   = IDLE_WORD;
    txc_nxt   = '1;
    und_nxt   = 1'b0;
    frm_done  = 1'b0;
    lane_adv  = 1'b0;
    if (!empty) begin
      lane_adv = 1'b1;
      case (state)
        ST_IDLE: begin
          txd_nxt = lane_d;
          txc_nxt = lane_c;
          if (is_start) state_nxt = ST_FRAME;
        end
        ST_FRAME: begin
          txd_nxt = lane_d;
          txc_nxt = lane_c;
          if (has_term) begin
            state_nxt = ST_IDLE;
            frm_done  = 1'b1;
          end
        end
        default: begin
          if (has_term) state_nxt = ST_IDLE;
        end
      endcase
    end else if ((state == ST_FRAME) && (lane_idx == '0)) begin
      // Starved mid-frame: poison the frame and discard its remainder
      txd_nxt   = ERR_WORD;
      txc_nxt   = '1;
      und_nxt   = 1'b1;
      state_nxt = ST_DROP;
    end
  end

  always_ff @(posedge clk156) begin
    if (push) mem[wr_ptr] <= {txc, txd};
  end

  always_ff @(posedge clk156 or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      lane_idx     <= '0;
      xgmii_txd    <= IDLE_WORD;
      xgmii_txc    <= '1;
      ovf_err      <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count        <= count + CNTW'(push) - CNTW'(pop);
      if (lane_adv) lane_idx <= lane_idx + LW'(1);
      xgmii_txd    <= txd_nxt;
      xgmii_txc    <= txc_nxt;
      ovf_err      <= in_vld && !in_rdy;
      underrun_err <= und_nxt;
    end
  end

`ifdef TX_XGMII_GEARBOX_STATS_EN
  always_ff @(posedge clk156 or posedge rst) begin
    if (rst) begin
      GBX_TX_FRM_CNT   <= '0;
      GBX_UNDERRUN_CNT <= '0;
    end else if (stats_clr) begin
      GBX_TX_FRM_CNT   <= '0;
      GBX_UNDERRUN_CNT <= '0;
    end else begin
      if (frm_done && (GBX_TX_FRM_CNT != '1))  GBX_TX_FRM_CNT   <= GBX_TX_FRM_CNT + 32'd1;
      if (und_nxt && (GBX_UNDERRUN_CNT != '1)) GBX_UNDERRUN_CNT <= GBX_UNDERRUN_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tx_xgmii_gearbox.sv
// tb/tb_tx_xgmii_gearbox.sv - self-checking bench for tx_xgmii_gearbox with lane-queue reference model
module tb_tx_xgmii_gearbox;

  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;

  logic         clk156 = 1'b0;
  logic         rst    = 1'b1;
  logic         in_vld = 1'b0;
  logic [255:0] txd    = '0;
  logic [31:0]  txc    = '0;
  logic         in_rdy;
  logic [63:0]  xgmii_txd;
  logic [7:0]   xgmii_txc;
  logic         ovf_err, underrun_err;
`ifdef TX_XGMII_GEARBOX_STATS_EN
  logic         stats_clr = 1'b0;
  logic [31:0]  GBX_TX_FRM_CNT, GBX_UNDERRUN_CNT;
`endif

  tx_xgmii_gearbox dut (
    .clk156       (clk156),
    .rst          (rst),
    .in_vld       (in_vld),
    .txd          (txd),
    .txc          (txc),
    .in_rdy       (in_rdy),
    .xgmii_txd    (xgmii_txd),
    .xgmii_txc    (xgmii_txc),
    .ovf_err      (ovf_err),
    .underrun_err (underrun_err)
`ifdef TX_XGMII_GEARBOX_STATS_EN
    ,
    .stats_clr        (stats_clr),
    .GBX_TX_FRM_CNT   (GBX_TX_FRM_CNT),
    .GBX_UNDERRUN_CNT (GBX_UNDERRUN_CNT)
`endif
  );

  always #5 clk156 = ~clk156;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the FIFO is a flat queue of {ctrl, data} lanes
  logic [71:0] lq[$];
  int          m_mode = 0;  // 0 idle, 1 in frame, 2 dropping
  logic [63:0] e_txd = IDLE_W;
  logic [7:0]  e_txc = 8'hFF;
  logic        e_ovf = 1'b0, e_und = 1'b0;
  int          m_frm = 0, m_und = 0;
  bit          g_in_frame = 0;

  typedef struct {
    logic         vld;
    logic [255:0] d;
    logic [31:0]  c;
    logic [63:0]  etxd;
    logic [7:0]   etxc;
    logic         erdy;
    logic         eovf;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [287:0] add_term(input logic [287:0] b, input int k);
    logic [287:0] r;
    r = b;
    for (int i = 8*k; i < 32; i++) begin
      r[8*i +: 8]     = (i == 8*k) ? 8'hFD : 8'h07;
      r[256 + i]      = 1'b1;
    end
    return r;
  endfunction

  // One clock: called at a negedge, returns at the following negedge
  task automatic step(input logic v, input logic [255:0] d, input logic [31:0] c);
    logic       rdy_exp;
    logic [63:0] ld;
    logic [7:0]  lc;
    logic        fd;
    rdy_exp = (((lq.size() + 3) / 4) < 2) || ((lq.size() % 4) == 1);
    chk("in_rdy", in_rdy, rdy_exp);
    in_vld = v; txd = d; txc = c;
    e_txd = IDLE_W; e_txc = 8'hFF; e_und = 1'b0;
    if (lq.size() > 0) begin
      {lc, ld} = lq.pop_front();
      fd = 1'b0;
      for (int b = 0; b < 8; b++) if (lc[b] && ld[8*b +: 8] == 8'hFD) fd = 1'b1;
      if (m_mode == 0) begin
        e_txd = ld; e_txc = lc;
        if (lc[0] && ld[7:0] == 8'hFB) m_mode = 1;
      end else if (m_mode == 1) begin
        e_txd = ld; e_txc = lc;
        if (fd) begin m_mode = 0; m_frm++; end
      end else if (fd) begin
        m_mode = 0;
      end
    end else if (m_mode == 1) begin
      e_txd = ERR_W; e_und = 1'b1; m_mode = 2; m_und++;
    end
    if (v && rdy_exp) for (int i = 0; i < 4; i++) lq.push_back({c[8*i +: 8], d[64*i +: 64]});
    e_ovf = v && !rdy_exp;
    @(posedge clk156);
    @(negedge clk156);
    in_vld = 1'b0;
    chk("xgmii_txd", xgmii_txd, e_txd);
    chk("xgmii_txc", xgmii_txc, e_txc);
    chk("ovf_err", ovf_err, e_ovf);
    chk("underrun_err", underrun_err, e_und);
  endtask

  task automatic gen_beat(output logic [255:0] d, output logic [31:0] c);
    logic [287:0] b;
    for (int i = 0; i < 32; i++) b[8*i +: 8] = 8'($urandom_range(0, 255));
    b[287:256] = '0;
    if (!g_in_frame) begin
      if ($urandom_range(0, 3) == 0) begin
        b[7:0] = 8'hFB; b[256] = 1'b1; g_in_frame = 1;
        if ($urandom_range(0, 2) == 0) begin
          b = add_term(b, $urandom_range(1, 3));
          g_in_frame = 0;
        end
      end else begin
        b = {32'hFFFFFFFF, {32{8'h07}}};
      end
    end else if ($urandom_range(0, 2) == 0) begin
      b = add_term(b, $urandom_range(0, 3));
      g_in_frame = 0;
    end
    d = b[255:0];
    c = b[287:256];
  endtask

  task automatic model_reset();
    lq.delete();
    m_mode = 0; m_frm = 0; m_und = 0; g_in_frame = 0;
  endtask

  logic [255:0] sb_d, tb_d, jk_d, rd;
  logic [31:0]  rc;

  initial begin
    sb_d = '0;
    sb_d[7:0] = 8'hFB;
    for (int k = 1; k < 32; k++) sb_d[8*k +: 8] = 8'(k);
    tb_d = {{31{8'h07}}, 8'hFD};
    jk_d = {8{32'hDEADBEEF}};

    vt[0] = '{1'b1, sb_d, 32'h1,        IDLE_W,                8'hFF, 1'b1, 1'b0};
    vt[1] = '{1'b1, tb_d, 32'hFFFFFFFF, 64'h07060504030201FB,  8'h01, 1'b0, 1'b0};
    vt[2] = '{1'b1, jk_d, 32'h0,        64'h0F0E0D0C0B0A0908,  8'h00, 1'b0, 1'b1};
    vt[3] = '{1'b0, '0,   32'h0,        64'h1716151413121110,  8'h00, 1'b1, 1'b0};
    vt[4] = '{1'b0, '0,   32'h0,        64'h1F1E1D1C1B1A1918,  8'h00, 1'b1, 1'b0};
    vt[5] = '{1'b0, '0,   32'h0,        64'h07070707070707FD,  8'hFF, 1'b1, 1'b0};
    for (int i = 6; i < 10; i++) vt[i] = '{1'b0, '0, 32'h0, IDLE_W, 8'hFF, 1'b1, 1'b0};

    repeat (3) @(negedge clk156);
    rst = 1'b0;
    chk("rst_txd", xgmii_txd, IDLE_W);
    chk("rst_txc", xgmii_txc, 8'hFF);
    chk("rst_rdy", in_rdy, 1'b1);
    repeat (3) step(1'b0, '0, '0);

    for (int i = 0; i < 10; i++) begin
      step(vt[i].vld, vt[i].d, vt[i].c);
      chk($sformatf("vec%0d_txd", i), xgmii_txd, vt[i].etxd);
      chk($sformatf("vec%0d_txc", i), xgmii_txc, vt[i].etxc);
      chk($sformatf("vec%0d_rdy", i), in_rdy, vt[i].erdy);
      chk($sformatf("vec%0d_ovf", i), ovf_err, vt[i].eovf);
    end

    // Start beat, then starvation
    step(1'b1, sb_d, 32'h1);
    repeat (4) step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    chk("und_word", xgmii_txd, ERR_W);
    chk("und_ctrl", xgmii_txc, 8'hFF);
    chk("und_pulse", underrun_err, 1'b1);
    repeat (7) step(1'b0, '0, '0);
    step(1'b1, jk_d, 32'h0);
    step(1'b1, tb_d, 32'hFFFFFFFF);
    repeat (7) begin
      step(1'b0, '0, '0);
      chk("drop_silent", xgmii_txd, IDLE_W);
    end
    step(1'b1, sb_d, 32'h1);
    step(1'b1, tb_d, 32'hFFFFFFFF);
    chk("after_drop_lane0", xgmii_txd, 64'h07060504030201FB);
    repeat (8) step(1'b0, '0, '0);

    // Asynchronous reset during lane 2 of a frame beat
    step(1'b1, sb_d, 32'h1);
    repeat (3) step(1'b0, '0, '0);
    chk("pre_rst_lane2", xgmii_txd, 64'h1716151413121110);
    #2 rst = 1'b1;
    #1;
    chk("arst_txd", xgmii_txd, IDLE_W);
    chk("arst_txc", xgmii_txc, 8'hFF);
    chk("arst_rdy", in_rdy, 1'b1);
    @(negedge clk156);
    rst = 1'b0;
    model_reset();
    step(1'b1, sb_d, 32'h1);
    step(1'b1, tb_d, 32'hFFFFFFFF);
    chk("post_rst_lane0", xgmii_txd, 64'h07060504030201FB);
    repeat (8) step(1'b0, '0, '0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) < 60) begin
        gen_beat(rd, rc);
        step(1'b1, rd, rc);
      end else begin
        step(1'b0, '0, '0);
      end
    end

`ifdef TX_XGMII_GEARBOX_STATS_EN
    chk("rnd_frm_cnt", GBX_TX_FRM_CNT, 64'(m_frm));
    chk("rnd_und_cnt", GBX_UNDERRUN_CNT, 64'(m_und));
    @(negedge clk156);
    rst = 1'b1;
    @(negedge clk156);
    rst = 1'b0;
    model_reset();
    for (int f = 0; f < 3; f++) begin
      step(1'b1, sb_d, 32'h1);
      step(1'b1, tb_d, 32'hFFFFFFFF);
      repeat (6) step(1'b0, '0, '0);
    end
    step(1'b1, sb_d, 32'h1);
    repeat (6) step(1'b0, '0, '0);
    step(1'b1, tb_d, 32'hFFFFFFFF);
    repeat (6) step(1'b0, '0, '0);
    chk("frm_cnt3", GBX_TX_FRM_CNT, 64'd3);
    chk("und_cnt1", GBX_UNDERRUN_CNT, 64'd1);
    stats_clr = 1'b1;
    step(1'b0, '0, '0);
    stats_clr = 1'b0;
    chk("clr_frm", GBX_TX_FRM_CNT, 64'd0);
    chk("clr_und", GBX_UNDERRUN_CNT, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
